// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite ROM arbitration path.
package sprite_pkg;

  localparam int SPR_W     = 32;
  localparam int SPR_H     = 24;
  localparam int COORD_W   = 6;
  localparam int SPR_SEL_W = 2;
  localparam int ID_MAX_W  = 3;

  typedef enum logic [SPR_SEL_W-1:0] {
    SPR_CAR   = 2'd0,
    SPR_TRUCK = 2'd1,
    SPR_LOG   = 2'd2,
    SPR_FROG  = 2'd3
  } spr_sel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  // id is sized for the largest supported requester count (8)
  typedef struct packed {
    logic [COORD_W-1:0]  dx;
    logic [COORD_W-1:0]  dy;
    logic                dir;
    spr_sel_t            sel;
    logic [ID_MAX_W-1:0] id;
    logic                oor;
    logic                valid;
  } stage_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter; the search starts at the pointer and the
// pointer moves past the winner on every issued grant.
module rr_arbiter #(
  parameter  int N   = 4,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic [N-1:0]   req_i,
  input  logic           en_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] gnt_id_o,
  output logic           gnt_valid_o
);

  localparam logic [IDW:0]   NUM  = (IDW+1)'(N);
  localparam logic [IDW-1:0] LAST = IDW'(N - 1);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] pick;
  logic [IDW:0]   idx;
  logic           found;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr_q} + (IDW+1)'(k);
      if (idx >= NUM) idx = idx - NUM;
      if (!found && req_i[idx[IDW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IDW-1:0];
      end
    end
  end

  assign gnt_valid_o = found && en_i;
  assign gnt_id_o    = pick;
  assign gnt_o       = gnt_valid_o ? (N'(1) << pick) : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_valid_o) ptr_d = (pick == LAST) ? '0 : pick + IDW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one combinational sprite-ROM port between NUM_REQ renderers with a
// two-stage pipeline: grant/address register, then registered ROM response.
//   state | meaning
//   IDLE  | nothing in flight, grants allowed when en is high
//   RUN   | granting and/or pipeline occupied
//   DRAIN | no grants, flushing in-flight stages
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int SPR_W   = sprite_pkg::SPR_W,
  parameter  int SPR_H   = sprite_pkg::SPR_H,
  parameter  int SEL_W   = 2,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   en_i,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [NUM_REQ*6-1:0]   req_dx_i,
  input  logic [NUM_REQ*6-1:0]   req_dy_i,
  input  logic [NUM_REQ-1:0]     req_dir_i,
  input  logic [NUM_REQ*SEL_W-1:0] req_sel_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  output logic [5:0]             rom_dx_o,
  output logic [5:0]             rom_dy_o,
  output logic                   rom_dir_o,
  output logic [SEL_W-1:0]       rom_sel_o,
  input  logic [7:0]             rom_data_i,
  output logic                   rsp_valid_o,
  output logic [IDW-1:0]         rsp_id_o,
  output logic [7:0]             rsp_data_o,
  output logic                   rsp_transp_o,
  output logic                   busy_o
);

  arb_state_t state_q, state_d;
  stage_t     s1_q, s1_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gnt_id;
  logic               gnt_valid;
  logic               any_req, pipe_empty, grant_en;

  logic [5:0]       f_dx, f_dy;
  logic             f_dir;
  logic [SEL_W-1:0] f_sel;

  logic           rsp_valid_q;
  logic [IDW-1:0] rsp_id_q;
  logic [7:0]     rsp_data_q;
  logic           rsp_transp_q;
  logic [7:0]     rd;
  logic           unused_id_bits;

  assign any_req    = |req_i;
  assign pipe_empty = !s1_q.valid && !rsp_valid_q;
  // rst_n_i gating keeps gnt low while reset is held, since gnt is combinational
  assign grant_en   = en_i && rst_n_i && (state_q != DRAIN);

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .req_i      (req_i),
    .en_i       (grant_en),
    .gnt_o      (gnt),
    .gnt_id_o   (gnt_id),
    .gnt_valid_o(gnt_valid)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en_i && any_req) state_d = RUN;
      RUN:     if (!en_i || (!any_req && pipe_empty)) state_d = DRAIN;
      DRAIN: begin
        if (pipe_empty) state_d = IDLE;
        else if (en_i)  state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    f_dx  = '0;
    f_dy  = '0;
    f_dir = 1'b0;
    f_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        f_dx  = req_dx_i[i*6 +: 6];
        f_dy  = req_dy_i[i*6 +: 6];
        f_dir = req_dir_i[i];
        f_sel = req_sel_i[i*SEL_W +: SEL_W];
      end
    end
  end

  always_comb begin
    s1_d = '0;
    if (gnt_valid) begin
      s1_d.valid = 1'b1;
      s1_d.dx    = f_dx;
      s1_d.dy    = f_dy;
      s1_d.dir   = f_dir;
      s1_d.sel   = spr_sel_t'(SPR_SEL_W'(f_sel));
      s1_d.id    = ID_MAX_W'(gnt_id);
      s1_d.oor   = (f_dx >= COORD_W'(SPR_W)) || (f_dy >= COORD_W'(SPR_H));
    end
  end

  assign rd = s1_q.oor ? 8'h00 : rom_data_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      s1_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      rsp_transp_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_q         <= s1_d;
      rsp_valid_q  <= s1_q.valid;
      rsp_id_q     <= s1_q.id[IDW-1:0];
      rsp_data_q   <= s1_q.valid ? rd : 8'h00;
      rsp_transp_q <= s1_q.valid && (rd == 8'h00);
    end
  end

  assign unused_id_bits = ^s1_q.id;

  assign gnt_o        = gnt;
  assign rom_dx_o     = s1_q.dx;
  assign rom_dy_o     = s1_q.dy;
  assign rom_dir_o    = s1_q.dir;
  assign rom_sel_o    = SEL_W'(s1_q.sel);
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_transp_o = rsp_transp_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a formula-based stub ROM.
module tb_sprite_rom_arbiter;
  import sprite_pkg::*;

  logic        clk, rst_n, en;
  logic [3:0]  req;
  logic [23:0] req_dx, req_dy;
  logic [3:0]  req_dir;
  logic [7:0]  req_sel;
  logic [3:0]  gnt;
  logic [5:0]  rom_dx, rom_dy;
  logic        rom_dir;
  logic [1:0]  rom_sel;
  logic [7:0]  rom_data;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        rsp_transp;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  sprite_rom_arbiter dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .en_i        (en),
    .req_i       (req),
    .req_dx_i    (req_dx),
    .req_dy_i    (req_dy),
    .req_dir_i   (req_dir),
    .req_sel_i   (req_sel),
    .gnt_o       (gnt),
    .rom_dx_o    (rom_dx),
    .rom_dy_o    (rom_dy),
    .rom_dir_o   (rom_dir),
    .rom_sel_o   (rom_sel),
    .rom_data_i  (rom_data),
    .rsp_valid_o (rsp_valid),
    .rsp_id_o    (rsp_id),
    .rsp_data_o  (rsp_data),
    .rsp_transp_o(rsp_transp),
    .busy_o      (busy)
  );

  // stub ROM: dx + 6*dy + 16*sel + 64*dir, truncated to 8 bits
  assign rom_data = 8'(rom_dx) + 8'(rom_dy) * 8'd6 + {2'b00, rom_sel, 4'b0000}
                  + {1'b0, rom_dir, 6'b000000};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [5:0] dx, input logic [5:0] dy,
                         input logic d, input logic [1:0] s);
    req_dx[i*6 +: 6] = dx;
    req_dy[i*6 +: 6] = dy;
    req_dir[i]       = d;
    req_sel[i*2 +: 2] = s;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 20) begin
      tick();
      #2;
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic run_single(input string tag, input int id, input logic [5:0] dx,
                            input logic [5:0] dy, input logic d, input logic [1:0] s,
                            input logic [7:0] exp_data, input logic exp_tr);
    tick();
    set_req(id, dx, dy, d, s);
    req = 4'b0001 << id;
    #2;
    check({tag, "_gnt"}, 32'(gnt), 32'(4'b0001 << id));
    tick();
    req = 4'b0000;
    #2;
    check({tag, "_gnt_off"}, 32'(gnt), 32'd0);
    check({tag, "_rom_dx"}, 32'(rom_dx), 32'(dx));
    check({tag, "_rom_dy"}, 32'(rom_dy), 32'(dy));
    tick();
    #2;
    check({tag, "_vld"}, 32'(rsp_valid), 32'd1);
    check({tag, "_id"}, 32'(rsp_id), 32'(id));
    check({tag, "_data"}, 32'(rsp_data), 32'(exp_data));
    check({tag, "_tr"}, 32'(rsp_transp), 32'(exp_tr));
    wait_idle({tag, "_idle"});
  endtask

  logic [3:0] exp_gnt [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                              4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 4'b1111;
    req_dx = '0; req_dy = '0; req_dir = '0; req_sel = '0;
    for (int i = 0; i < 4; i++) set_req(i, 6'(i + 1), 6'(i), 1'b0, SPR_CAR);

    // reset values
    tick(); tick();
    #2;
    check("rst_gnt",   32'(gnt), 32'd0);
    check("rst_vld",   32'(rsp_valid), 32'd0);
    check("rst_id",    32'(rsp_id), 32'd0);
    check("rst_data",  32'(rsp_data), 32'd0);
    check("rst_tr",    32'(rsp_transp), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_romdx", 32'(rom_dx), 32'd0);
    check("rst_romdy", 32'(rom_dy), 32'd0);

    // all four requesting: strict rotation, responses two cycles later
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 0) rst_n = 1'b1;
      #2;
      check($sformatf("rot_gnt%0d", k), 32'(gnt), 32'(exp_gnt[k]));
      if (k >= 2) begin
        check($sformatf("rot_vld%0d", k), 32'(rsp_valid), 32'd1);
        check($sformatf("rot_id%0d", k), 32'(rsp_id), 32'((k - 2) % 4));
        check($sformatf("rot_data%0d", k), 32'(rsp_data), 32'(7 * ((k - 2) % 4) + 1));
      end
    end

    // reset mid-pipeline
    tick();
    rst_n = 1'b0;
    #2;
    check("mrst_gnt",   32'(gnt), 32'd0);
    check("mrst_vld",   32'(rsp_valid), 32'd0);
    check("mrst_romdx", 32'(rom_dx), 32'd0);
    check("mrst_busy",  32'(busy), 32'd0);
    check("mrst_data",  32'(rsp_data), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #2;
    check("mrst_first_gnt", 32'(gnt), 32'd1);
    check("mrst_vld0", 32'(rsp_valid), 32'd0);
    tick();
    req = 4'b0000;
    #2;
    check("mrst_gnt1", 32'(gnt), 32'd0);
    check("mrst_vld1", 32'(rsp_valid), 32'd0);
    tick();
    #2;
    check("mrst_vld2", 32'(rsp_valid), 32'd1);
    check("mrst_id2",  32'(rsp_id), 32'd0);
    wait_idle("mrst_idle");

    // single-request vectors incl. range boundaries
    run_single("car",    2,  6'd5,  6'd3, 1'b0, SPR_CAR,   8'd23,  1'b0);
    run_single("dx40",   1, 6'd40,  6'd3, 1'b0, SPR_CAR,   8'd0,   1'b1);
    run_single("edge",   3, 6'd31, 6'd23, 1'b0, SPR_CAR,   8'd169, 1'b0);
    run_single("dy24",   0, 6'd10, 6'd24, 1'b0, SPR_CAR,   8'd0,   1'b1);
    run_single("zero",   2,  6'd0,  6'd0, 1'b0, SPR_CAR,   8'd0,   1'b1);
    run_single("truck",  0,  6'd2,  6'd1, 1'b1, SPR_TRUCK, 8'd88,  1'b0);

    // en dropped with two responses in flight (pointer is 1 here)
    tick();
    req = 4'b0011;
    #2;
    check("en_gnt0", 32'(gnt), 32'b0010);
    tick();
    req = 4'b0001;
    #2;
    check("en_gnt1", 32'(gnt), 32'b0001);
    tick();
    en  = 1'b0;
    req = 4'b0011;
    #2;
    check("en_gnt2", 32'(gnt), 32'd0);
    check("en_vld2", 32'(rsp_valid), 32'd1);
    check("en_id2",  32'(rsp_id), 32'd1);
    check("en_busy2", 32'(busy), 32'd1);
    tick();
    #2;
    check("en_gnt3", 32'(gnt), 32'd0);
    check("en_vld3", 32'(rsp_valid), 32'd1);
    check("en_id3",  32'(rsp_id), 32'd0);
    check("en_busy3", 32'(busy), 32'd1);
    tick();
    #2;
    check("en_gnt4", 32'(gnt), 32'd0);
    check("en_vld4", 32'(rsp_valid), 32'd0);
    tick();
    #2;
    check("en_gnt5", 32'(gnt), 32'd0);
    check("en_vld5", 32'(rsp_valid), 32'd0);
    check("en_busy5", 32'(busy), 32'd0);
    req = 4'b0000;
    en  = 1'b1;

    // single persistent requester granted every cycle
    set_req(3, 6'd7, 6'd2, 1'b0, SPR_CAR);
    for (int k = 0; k < 8; k++) begin
      tick();
      req = (k < 5) ? 4'b1000 : 4'b0000;
      #2;
      check($sformatf("p3_gnt%0d", k), 32'(gnt), (k < 5) ? 32'b1000 : 32'd0);
      if (k >= 2) begin
        check($sformatf("p3_vld%0d", k), 32'(rsp_valid), (k <= 6) ? 32'd1 : 32'd0);
        if (k <= 6) begin
          check($sformatf("p3_id%0d", k), 32'(rsp_id), 32'd3);
          check($sformatf("p3_data%0d", k), 32'(rsp_data), 32'd19);
        end
      end
    end
    wait_idle("p3_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one combinational sprite-ROM read port (24x32 sprites, 8-bit palette index) between NUM_REQ object renderers: cars, trucks and logs.
- Each renderer presents a pixel coordinate plus sprite select. The arbiter grants one requester per cycle, round-robin, and drives the shared ROM address.
- The ROM output is registered and returned, tagged with the requester ID and a transparency flag.
- Sits between the per-lane object renderers and the sprite ROM mux, ahead of the color mapper.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SPR_W, 32, sprite width in pixels; DX values >= SPR_W are out of range.
- SPR_H, 24, sprite height in pixels; DY values >= SPR_H are out of range.
- SEL_W, 2, width of the sprite-select field.

Ports:
- Clk, input, 1: system clock.
- Reset_n, input, 1: asynchronous active-low reset.
- en, input, 1: arbitration enable; low means no new grants.
- req, input, NUM_REQ: per-requester request.
- req_dx, input, NUM_REQ*6: packed DX per requester.
- req_dy, input, NUM_REQ*6: packed DY per requester.
- req_dir, input, NUM_REQ: direction per requester.
- req_sel, input, NUM_REQ*SEL_W: sprite select per requester.
- gnt, output, NUM_REQ: one-hot grant; request accepted this cycle.
- rom_DX, output, 6: shared ROM X address.
- rom_DY, output, 6: shared ROM Y address.
- rom_dir, output, 1: shared ROM direction.
- rom_sel, output, SEL_W: shared ROM sprite select.
- rom_data, input, 8: ROM palette index, combinational from the rom_* outputs.
- rsp_valid, output, 1: response valid.
- rsp_id, output, clog2(NUM_REQ): ID of the requester the response belongs to.
- rsp_data, output, 8: palette index.
- rsp_transp, output, 1: high when rsp_data == 0.
- busy, output, 1: high when not in the IDLE state.

Behaviour:
- Reset (async assert, sync deassert):
  - gnt = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_transp = 0, busy = 0.
  - rom_* outputs = 0, round-robin pointer = 0, FSM = IDLE.
- Handshake:
  - A requester holds req high with its fields stable until it sees gnt.
  - gnt is combinational from req, pointer, FSM state and en.
  - The request is consumed in the same cycle gnt is high. The requester may change its fields or drop req on the next cycle.
- Arbitration:
  - Grant the first asserted req at or after the pointer, wrapping modulo NUM_REQ.
  - After a grant to index i, the pointer becomes (i+1) mod NUM_REQ. With no grant the pointer holds.
  - At most one gnt bit is high per cycle, and never when en = 0.
- Pipeline (latency 2):
  - Cycle N: grant; stage-1 registers capture dx, dy, dir, sel, id and an out-of-range flag (dx >= SPR_W or dy >= SPR_H). Stage-1 registers drive rom_*.
  - Cycle N+1: ROM read.
  - Cycle N+2: rsp_valid = 1; rsp_data = rom_data registered, or 0 if out-of-range; rsp_transp = (rsp_data == 0).
  - Throughput is one response per cycle. There is no backpressure on the response side.
- FSM:
  - IDLE -> RUN when en = 1 and any req is high.
  - RUN -> DRAIN when en = 0, or when no req is high and the pipeline is empty.
  - RUN stays in RUN while en = 1 and any req is high or the pipeline is occupied.
  - DRAIN issues no grants. It lets in-flight stages complete and goes to IDLE when both stage valids are 0.
  - DRAIN -> RUN directly if en returns high while the pipeline is still non-empty.
- Boundary rules:
  - Out-of-range coordinates produce rsp_data = 0 and rsp_transp = 1.
  - All requesters asserting together are served in strict rotation.
  - en falling in the same cycle as a req rising: no grant.
  - Reset mid-pipeline discards in-flight responses; no rsp_valid follows the reset.
  - A single persistent requester is granted every cycle.

Decomposition:
- Shared package sprite_pkg:
  - SPR_W and SPR_H constants.
  - sprite select enum: SPR_CAR = 0, SPR_TRUCK = 1, SPR_LOG = 2, SPR_FROG = 3.
  - arb_state_t enum: IDLE, RUN, DRAIN.
  - Stage record typedef: dx, dy, dir, sel, id, oor, valid.
- One sub-module, rr_arbiter: parameterised round-robin one-hot grant with the pointer register.

Test Plan:
- Reset_n low mid-stream with req = 4'b1111 -> all outputs 0 immediately; after release, first gnt = 4'b0001 (pointer 0).
- req = 4'b1111 held for 8 cycles -> gnt sequence 0001, 0010, 0100, 1000, repeating; rsp_id = 0, 1, 2, 3 appearing 2 cycles after each grant.
- Requester 2 with DX = 5, DY = 3, sel = SPR_CAR, stub ROM returning 23 -> rsp_valid 2 cycles later, rsp_id = 2, rsp_data = 23, rsp_transp = 0.
- Requester 1 with DX = 40 (>= 32) -> rsp_data = 0, rsp_transp = 1.
- en dropped while two responses are in flight -> no further gnt, 2 more rsp_valid pulses, then busy = 0 and FSM = IDLE.
- Only req[3] held for 5 cycles -> gnt[3] high every cycle, 5 consecutive responses.
